// File: rtl/mdu_div_issuer.sv
// Requester-side front end for DivisorUnit: accepts div/rem requests, resolves
// divide-by-zero and signed overflow locally, issues the rest and returns results.
module mdu_div_issuer #(
   parameter int parallelism = 32,
   parameter int TIMEOUT     = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [parallelism-1:0] req_dividend,
   input  logic [parallelism-1:0] req_divisor,
   output logic                   div_valid,
   output logic                   div_usigned,
   output logic [parallelism-1:0] div_dividend,
   output logic [parallelism-1:0] div_divisor,
   input  logic [parallelism-1:0] div_quotient,
   input  logic [parallelism-1:0] div_reminder,
   input  logic                   div_res_ready,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [parallelism-1:0] resp_data,
   output logic                   resp_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]          CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]          CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]          CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [parallelism-1:0] ZERO     = {parallelism{1'b0}};
   localparam logic [parallelism-1:0] ALL_ONES = {parallelism{1'b1}};
   localparam logic [parallelism-1:0] MIN_NEG  = {1'b1, {(parallelism-1){1'b0}}};

   state_t          state_r;
   logic [1:0]      op_r;
   logic [CW-1:0]   cnt_r;
   logic            is_zero_div_s;
   logic            is_ovf_s;

   // Classify the request on the port: the two cases answered without the divider
   always_comb begin
      is_zero_div_s = (req_divisor == ZERO);
      is_ovf_s      = (req_op[0] == 1'b0) && (req_dividend == MIN_NEG) &&
                      (req_divisor == ALL_ONES);
   end

   // Issue FSM with registered handshake, divider and response outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         op_r         <= 2'b00;
         cnt_r        <= CNT_ZERO;
         req_ready    <= 1'b1;
         div_valid    <= 1'b0;
         div_usigned  <= 1'b0;
         div_dividend <= ZERO;
         div_divisor  <= ZERO;
         resp_valid   <= 1'b0;
         resp_data    <= ZERO;
         resp_err     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_r      <= req_op;
                  req_ready <= 1'b0;
                  if (is_zero_div_s) begin
                     state_r    <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_data  <= req_op[1] ? req_dividend : ALL_ONES;
                  end else if (is_ovf_s) begin
                     state_r    <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_data  <= req_op[1] ? ZERO : req_dividend;
                  end else begin
                     state_r      <= ISSUE;
                     cnt_r        <= CNT_ZERO;
                     div_valid    <= 1'b1;
                     div_usigned  <= req_op[0];
                     div_dividend <= req_dividend;
                     div_divisor  <= req_divisor;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ISSUE, WAIT: begin
               div_valid <= 1'b0;
               // A result arriving on the watchdog's last cycle still wins
               if (div_res_ready) begin
                  state_r      <= DONE;
                  resp_valid   <= 1'b1;
                  resp_err     <= 1'b0;
                  resp_data    <= op_r[1] ? div_reminder : div_quotient;
                  div_usigned  <= 1'b0;
                  div_dividend <= ZERO;
                  div_divisor  <= ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r      <= DONE;
                  resp_valid   <= 1'b1;
                  resp_err     <= 1'b1;
                  resp_data    <= ZERO;
                  div_usigned  <= 1'b0;
                  div_dividend <= ZERO;
                  div_divisor  <= ZERO;
               end else begin
                  state_r <= WAIT;
                  cnt_r   <= cnt_r + CNT_ONE;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state_r    <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_data  <= ZERO;
               end else begin
                  resp_valid <= 1'b1;
               end
            end
            default: begin
               state_r      <= IDLE;
               req_ready    <= 1'b1;
               div_valid    <= 1'b0;
               div_usigned  <= 1'b0;
               div_dividend <= ZERO;
               div_divisor  <= ZERO;
               resp_valid   <= 1'b0;
               resp_err     <= 1'b0;
               resp_data    <= ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_div_issuer.sv
// Directed self-checking bench for mdu_div_issuer; the divider is played by hand.
module tb_mdu_div_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_dividend;
   logic [31:0] req_divisor;
   logic        div_valid;
   logic        div_usigned;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic [31:0] div_quotient;
   logic [31:0] div_reminder;
   logic        div_res_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   int errors = 0;
   int checks = 0;

   mdu_div_issuer #(.parallelism(32), .TIMEOUT(128)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .div_valid(div_valid), .div_usigned(div_usigned),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_reminder(div_reminder),
      .div_res_ready(div_res_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request; returns one step after the acceptance edge
   task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid    = 1'b1;
      req_op       = op;
      req_dividend = a;
      req_divisor  = b;
      tick();
      req_valid    = 1'b0;
      req_dividend = 32'h0;
      req_divisor  = 32'h0;
   endtask

   task automatic handshake(input string name);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_release: resp_valid=%b req_ready=%b, want 0 1", name, resp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_op = 2'b00; req_dividend = 32'h0; req_divisor = 32'h0;
      div_quotient = 32'h0; div_reminder = 32'h0; div_res_ready = 1'b0; resp_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || div_valid !== 1'b0 ||
          resp_err !== 1'b0 || resp_data !== 32'h0 || div_usigned !== 1'b0 ||
          div_dividend !== 32'h0 || div_divisor !== 32'h0) begin
         errors++;
         $display("FAIL reset: rr=%b rv=%b dv=%b err=%b data=%h us=%b dd=%h ds=%h, want 1 0 0 0 0 0 0 0",
                  req_ready, resp_valid, div_valid, resp_err, resp_data, div_usigned, div_dividend, div_divisor);
      end
   endtask

   task automatic test_normal(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                              input logic [31:0] exp);
      int pulses;
      int unstable;
      drive_req(op, a, b);
      pulses = 0;
      unstable = 0;
      checks++;
      if (div_valid !== 1'b1 || div_usigned !== op[0] || div_dividend !== a ||
          div_divisor !== b || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_issue: dv=%b us=%b dd=%h ds=%h rr=%b rv=%b, want 1 %b %h %h 0 0",
                  name, div_valid, div_usigned, div_dividend, div_divisor, req_ready, resp_valid, op[0], a, b);
      end
      if (div_valid === 1'b1) pulses++;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (div_valid === 1'b1) pulses++;
         if (div_dividend !== a || div_divisor !== b || div_usigned !== op[0] || resp_valid !== 1'b0)
            unstable++;
      end
      checks++;
      if (pulses != 1 || unstable != 0) begin
         errors++;
         $display("FAIL %s_wait: div_valid pulses=%0d unstable=%0d, want 1 0", name, pulses, unstable);
      end
      div_quotient  = q;
      div_reminder  = r;
      div_res_ready = 1'b1;
      tick();
      div_res_ready = 1'b0;
      div_quotient  = 32'hDEAD_BEEF;
      div_reminder  = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp || resp_err !== 1'b0 || div_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_resp: rv=%b data=%h err=%b dv=%b, want 1 %h 0 0",
                  name, resp_valid, resp_data, resp_err, div_valid, exp);
      end
      handshake(name);
   endtask

   task automatic test_shortcut(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
      drive_req(op, a, b);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp || resp_err !== 1'b0 ||
          div_valid !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s: rv=%b data=%h err=%b dv=%b rr=%b, want 1 %h 0 0 0",
                  name, resp_valid, resp_data, resp_err, div_valid, req_ready, exp);
      end
      handshake(name);
   endtask

   task automatic test_timeout();
      int n;
      drive_req(2'b01, 32'h75, 32'hA);
      n = 0;
      while (resp_valid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n != 128 || resp_err !== 1'b1 || resp_data !== 32'h0) begin
         errors++;
         $display("FAIL timeout: cycles=%0d err=%b data=%h, want 128 1 00000000", n, resp_err, resp_data);
      end
      div_quotient  = 32'h5555_5555;
      div_res_ready = 1'b1;
      tick();
      div_res_ready = 1'b0;
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0) begin
         errors++;
         $display("FAIL stray_in_done: rv=%b err=%b data=%h, want 1 1 00000000", resp_valid, resp_err, resp_data);
      end
      handshake("timeout");
      div_res_ready = 1'b1;
      tick();
      div_res_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL stray_in_idle: bad cycles=%0d, want 0", n);
      end
   endtask

   task automatic test_timeout_race();
      drive_req(2'b00, 32'h64, 32'h7);
      repeat (127) tick();
      div_quotient  = 32'hE;
      div_reminder  = 32'h2;
      div_res_ready = 1'b1;
      tick();
      div_res_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'hE) begin
         errors++;
         $display("FAIL timeout_race: rv=%b err=%b data=%h, want 1 0 0000000e", resp_valid, resp_err, resp_data);
      end
      handshake("timeout_race");
   endtask

   task automatic test_backpressure();
      int bad;
      drive_req(2'b00, 32'h42, 32'h0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF || req_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold: bad cycles=%0d, want 0", bad);
      end
      handshake("backpressure");
   endtask

   task automatic test_reset_in_wait();
      int bad;
      drive_req(2'b11, 32'h100, 32'h3);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      div_quotient  = 32'h55;
      div_res_ready = 1'b1;
      tick();
      div_res_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (resp_valid !== 1'b0 || req_ready !== 1'b1 || div_valid !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_in_wait: bad cycles=%0d, want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_normal("divu", 2'b01, 32'h75, 32'hA, 32'hB, 32'h7, 32'hB);
      test_normal("remu", 2'b11, 32'h75, 32'hA, 32'hB, 32'h7, 32'h7);
      test_normal("div_signed", 2'b00, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      test_normal("rem_signed", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      test_normal("remu_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000);
      test_shortcut("div_by_zero", 2'b00, 32'h1234, 32'h0, 32'hFFFF_FFFF);
      test_shortcut("divu_by_zero", 2'b01, 32'h1234, 32'h0, 32'hFFFF_FFFF);
      test_shortcut("rem_by_zero", 2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678);
      test_shortcut("remu_by_zero", 2'b11, 32'h8765_4321, 32'h0, 32'h8765_4321);
      test_shortcut("div_overflow", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      test_shortcut("rem_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
      test_timeout();
      test_timeout_race();
      test_backpressure();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu_div_issuer.md
Name: mdu_div_issuer

Overview:
Requester-side front end for DivisorUnit. Accepts RISC-V style divide/remainder requests over a valid/ready port and handles divide-by-zero and signed-overflow cases locally. All other requests are issued to DivisorUnit, whose result is captured and returned over a valid/ready response port. It sits between the decode/issue stage and DivisorUnit inside the multiply-division unit.

Parameters:
parallelism, 32, operand/result width in bits
TIMEOUT, 128, maximum cycles to wait for div_res_ready before aborting with error

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_dividend  in  parallelism  dividend operand
req_divisor  in  parallelism  divisor operand
div_valid  out  1  start pulse to DivisorUnit
div_usigned  out  1  1 = unsigned division
div_dividend  out  parallelism  operand to DivisorUnit
div_divisor  out  parallelism  operand to DivisorUnit
div_quotient  in  parallelism  DivisorUnit quotient
div_reminder  in  parallelism  DivisorUnit remainder
div_res_ready  in  1  DivisorUnit result valid, one-cycle pulse
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid&&resp_ready
resp_data  out  parallelism  selected quotient or remainder
resp_err  out  1  1 = divider timed out; resp_data is 0

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE. All outputs 0 except req_ready, which is 1 in IDLE. Reset cancels any in-flight operation. A div_res_ready arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On acceptance, latch op, dividend and divisor. Then:
  - divisor==0 goes to DONE with result all-ones for DIV/DIVU, or the dividend for REM/REMU.
  - Signed op (00/10) with dividend==1<<(parallelism-1) and divisor all-ones goes to DONE with result = dividend for DIV, 0 for REM.
  - Otherwise go to ISSUE.
- ISSUE: div_valid=1 for exactly this one cycle; next state WAIT. div_usigned=op[0].
- WAIT: stays here until div_res_ready.
- While in ISSUE and WAIT, div_dividend, div_divisor and div_usigned are held stable from the latched values. They are 0 in IDLE.
- div_res_ready is honoured in ISSUE and WAIT and ignored in IDLE and DONE.
- On div_res_ready: capture div_quotient if op[1]==0, else div_reminder; go to DONE.
- Watchdog: a counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT-1 without div_res_ready, go to DONE with resp_err=1 and resp_data=0. If div_res_ready coincides with the timeout cycle, the result wins and resp_err=0.
- DONE: resp_valid=1, with resp_data and resp_err registered and stable until the handshake. On resp_valid&&resp_ready go to IDLE. req_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency, acceptance edge to resp_valid:
  - Shortcut cases: 1 cycle.
  - Normal cases: 2 cycles plus divider latency, where the divider latency is counted from div_valid to div_res_ready.
- Only one operation is in flight at a time. Response backpressure stalls indefinitely in DONE with no loss.
- Widths: all data paths are parallelism bits. No sign manipulation is done here; DivisorUnit handles signedness via div_usigned.

Test Plan:
- DIVU with dividend 0x75 and divisor 0xA, divider returning q=0xB, r=0x7: div_valid pulses once with usigned=1, then resp_data=0xB and resp_err=0. The same operands with REMU give resp_data=0x7.
- DIV with divisor 0: no div_valid, and resp_valid one cycle after acceptance with resp_data=0xFFFFFFFF. REM with dividend 0x12345678 and divisor 0 gives resp_data=0x12345678.
- DIV with dividend 0x80000000 and divisor 0xFFFFFFFF: shortcut, resp_data=0x80000000. REM with the same operands gives resp_data=0.
- Divider never asserts div_res_ready: after TIMEOUT=128 cycles, resp_valid=1, resp_err=1, resp_data=0. A stray div_res_ready later, while in IDLE or DONE, is ignored.
- resp_ready held low for 10 cycles: resp_data stays stable and req_ready stays 0. The response completes on the first resp_ready; req_ready returns to 1 on the following cycle.
- rst_n dropped during WAIT and released, then div_res_ready pulses: the block stays in IDLE with req_ready=1 and never asserts resp_valid.
